// File: rtl/mem_responder.sv
// mem_responder: pipelined 16-bit word memory for CPU fetch and load/store traffic.
//
// Accepts one request on every rising edge where req_valid is high (there is no stall or ready).
// Writes update the array at the accept edge and produce no response. Reads sample the array
// contents from before the accept edge. The sample then travels down a LATENCY-deep
// {valid, data} pipeline that advances every cycle. rsp_valid/rsp_rdata come from the last
// stage, so a read is visible after LATENCY edges counting its accept edge.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset (array contents are kept)
//   req_valid    request present this cycle
//   req_wr       1 = write, 0 = read
//   req_addr     byte address; word index = req_addr[ADDR_W:1], other bits ignored
//   req_wdata    write data
//   rsp_valid    rsp_rdata carries a read result
//   rsp_rdata    read data, holds its last value while rsp_valid is low
//   busy         at least one read in flight
//   outstanding  reads accepted but not yet returned (max LATENCY)
module mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [3:0]  outstanding
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [15:0]       mem [Depth];
  logic [ADDR_W-1:0] idx;
  logic              wr_en;
  logic              rd_en;
  logic              retire;

  logic [LATENCY-1:0] valid_q;
  logic [15:0]        data_q [LATENCY];
  logic [3:0]         outstanding_q;
  logic [3:0]         outstanding_d;

  // Bit 0 and the bits above the word index alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  assign idx    = req_addr[ADDR_W:1];
  assign wr_en  = req_valid & req_wr;
  assign rd_en  = req_valid & ~req_wr;
  assign retire = valid_q[LATENCY-1];

  // The array has no reset; a request seen while rst_n is low must not write it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[idx] <= req_wdata;
    end
  end

  // Stage 0 captures the pre-edge array contents. A stage's data only moves when its
  // predecessor is valid, so the last stage (and rsp_rdata) holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        data_q[i] <= 16'h0000;
      end
    end else begin
      valid_q[0] <= rd_en;
      if (rd_en) begin
        data_q[0] <= mem[idx];
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  // Accept and retire may coincide; they cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({rd_en, retire})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= 4'd0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    rsp_valid   = valid_q[LATENCY-1];
    rsp_rdata   = data_q[LATENCY-1];
    outstanding = outstanding_q;
    busy        = (outstanding_q != 4'd0);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=4 and one with LATENCY=1 share the same
// request stream. A reference model (plain array plus per-instance queues of expected
// {data, due cycle}) is updated at each accept edge; monitors on the falling edge pop and compare.
module tb_mem_responder;

  localparam int unsigned AW = 10;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  logic        rsp_valid4, rsp_valid1;
  logic [15:0] rsp_rdata4, rsp_rdata1;
  logic        busy4, busy1;
  logic [3:0]  outstanding4, outstanding1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [15:0] model_mem [1 << AW];
  exp_t        q4 [$];
  exp_t        q1 [$];

  mem_responder #(.ADDR_W(AW), .LATENCY(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid4),
    .rsp_rdata   (rsp_rdata4),
    .busy        (busy4),
    .outstanding (outstanding4)
  );

  mem_responder #(.ADDR_W(AW), .LATENCY(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid1),
    .rsp_rdata   (rsp_rdata1),
    .busy        (busy1),
    .outstanding (outstanding1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int widx(input logic [15:0] addr);
    return (int'(addr) >> 1) % (1 << AW);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: acts at the accept edge on what the bench itself drove.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && req_valid) begin
      if (req_wr) begin
        model_mem[widx(req_addr)] <= req_wdata;
      end else begin
        q4.push_back('{model_mem[widx(req_addr)], cyc + 4});
        q1.push_back('{model_mem[widx(req_addr)], cyc + 1});
      end
    end
  end

  // In-flight reads are discarded by reset.
  always @(negedge rst_n) begin
    q4.delete();
    q1.delete();
  end

  always @(negedge clk) begin
    chk("outstanding4", int'(outstanding4), q4.size());
    chk("busy4", int'(busy4), int'(q4.size() != 0));
    chk("rsp_valid4_expected", int'(rsp_valid4), int'(rsp_valid4 && q4.size() != 0));
    if (rsp_valid4 && q4.size() != 0) begin
      automatic exp_t e;
      e = q4.pop_front();
      chk("rdata4", int'(rsp_rdata4), int'(e.data));
      chk("latency4", cyc, e.due);
    end
  end

  always @(negedge clk) begin
    chk("outstanding1", int'(outstanding1), q1.size());
    chk("busy1", int'(busy1), int'(q1.size() != 0));
    chk("rsp_valid1_expected", int'(rsp_valid1), int'(rsp_valid1 && q1.size() != 0));
    if (rsp_valid1 && q1.size() != 0) begin
      automatic exp_t e;
      e = q1.pop_front();
      chk("rdata1", int'(rsp_rdata1), int'(e.data));
      chk("latency1", cyc, e.due);
    end
  end

  task automatic req(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int waited;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata4", int'(rsp_rdata4), 0);
    chk("reset_rdata1", int'(rsp_rdata1), 0);
    chk("reset_valid4", int'(rsp_valid4), 0);
    chk("reset_outstanding4", int'(outstanding4), 0);
    rst_n = 1'b1;

    // Fill every word, scrambling the aliased address bits.
    for (int i = 0; i < (1 << AW); i++) begin
      automatic logic [15:0] a;
      a = 16'(i << 1);
      a[15:AW+1] = 5'($urandom);
      a[0]       = 1'($urandom);
      req(1'b1, a, 16'($urandom));
    end

    // Basic read of word 3.
    req(1'b1, 16'h0006, 16'hBEEF);
    idle(2);
    req(1'b0, 16'h0006, 16'h0000);
    idle(6);

    // Write then read the same word next cycle, bit 0 differs.
    req(1'b1, 16'h0010, 16'h1234);
    req(1'b0, 16'h0011, 16'h0000);
    idle(6);

    // Streaming reads of words 0..7.
    for (int i = 0; i < 8; i++) req(1'b1, 16'(i * 2), 16'(16'h00A0 + i));
    for (int i = 0; i < 8; i++) req(1'b0, 16'(i * 2), 16'h0000);
    idle(8);

    // Interleaved read/write/read of word 5.
    req(1'b1, 16'h000A, 16'h5555);
    req(1'b0, 16'h000A, 16'h0000);
    req(1'b1, 16'h000A, 16'hAAAA);
    req(1'b0, 16'h000A, 16'h0000);
    idle(6);

    // Aliasing: 0x0802 and 0x0002 name the same word.
    req(1'b1, 16'h0802, 16'hC0DE);
    req(1'b0, 16'h0002, 16'h0000);
    idle(6);

    // Reset with two reads in flight; a write presented during reset is ignored.
    req(1'b0, 16'h0006, 16'h0000);
    req(1'b0, 16'h0008, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid4", int'(rsp_valid4), 0);
    chk("async_rst_outstanding4", int'(outstanding4), 0);
    chk("async_rst_busy4", int'(busy4), 0);
    req(1'b1, 16'h0012, 16'hDEAD);
    idle(1);
    rst_n = 1'b1;
    req(1'b0, 16'h0012, 16'h0000);
    req(1'b0, 16'h0010, 16'h0000);
    idle(6);

    // Random traffic concentrated on a few words to exercise hazards.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        automatic logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(0, 3) != 0) a[AW:1] = AW'($urandom_range(0, 15));
        req(1'($urandom), a, 16'($urandom));
      end else begin
        idle(1);
      end
    end

    waited = 0;
    while ((q4.size() != 0 || q1.size() != 0) && waited < 40) begin
      idle(1);
      waited++;
    end
    chk("drain4", q4.size(), 0);
    chk("drain1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
